// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its consumer.
// The receiver side (master) owns the decoded byte and strobes; the line side drives rx_in.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (input rx_in, output data_out, data_valid, frame_err, busy);
    modport slave  (output rx_in, input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an internal 16x oversampling tick.
// Each bit is sampled once at its centre; results are presented as registered one-cycle strobes.
module uart_rx #(
    parameter int CLK_FREQ   = 200_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk_in,
    input  logic      rst_n,
    uart_rx_if.master bus
);
    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    logic rx_s;
    logic start_edge;
    logic tick;

    assign rx_s       = sync2_q;
    assign start_edge = rx_prev_q & ~rx_s;
    assign tick       = (baud_q == DIV_LAST);

    always_comb begin
        sync1_d    = bus.rx_in;
        sync2_d    = sync1_q;
        rx_prev_d  = sync2_q;
        state_d    = state_q;
        baud_d     = '0;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        // The tick divider only runs while a frame is in progress.
        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_idx_q] = rx_s;
                        bit_idx_d          = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    // Leaving at mid stop bit lets a back-to-back start edge be caught.
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            baud_q     <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rx_prev_q  <= rx_prev_d;
            baud_q     <= baud_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
